// File: rtl/alu_share_ctrl_pkg.sv
// rtl/alu_share_ctrl_pkg.sv - shared constants, state type and flag helper for the ALU share controller
package alu_share_ctrl_pkg;

    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_MVN = 4'b1001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;

    // ALU status bit positions, order {N,Z,V,C}
    localparam int SB_N = 3;
    localparam int SB_Z = 2;
    localparam int SB_V = 1;
    localparam int SB_C = 0;

    // Architectural flag bit positions, order {N,Z,C,V}
    localparam int FL_N = 3;
    localparam int FL_Z = 2;
    localparam int FL_C = 1;
    localparam int FL_V = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // The ALU and the flag register order V and C differently.
    function automatic logic [3:0] status_to_flags(input logic [3:0] st);
        logic [3:0] fl;
        fl        = 4'b0000;
        fl[FL_N]  = st[SB_N];
        fl[FL_Z]  = st[SB_Z];
        fl[FL_C]  = st[SB_C];
        fl[FL_V]  = st[SB_V];
        return fl;
    endfunction

endpackage

// File: rtl/alu_share_ctrl_rr_arbiter2.sv
// rtl/alu_share_ctrl_rr_arbiter2.sv - two-input round-robin grant with last_grant state
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    input  logic       accept,
    output logic       grant
);

    logic last_grant;

    always_comb begin
        grant = 1'b0;
        if (valid == 2'b11) begin
            grant = ~last_grant;
        end else if (valid[1]) begin
            grant = 1'b1;
        end
    end

    // Resets to 1 so requester 0 wins the first contested round.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= grant;
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// rtl/alu_share_ctrl.sv - sequencer/arbiter sharing one combinational ALU between two requesters
module alu_share_ctrl
    import alu_share_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CMD_W  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [1:0][CMD_W-1:0]  req_cmd,
    input  logic [1:0][DATA_W-1:0] req_a,
    input  logic [1:0][DATA_W-1:0] req_b,
    input  logic [1:0]             req_s,
    output logic [1:0]             rsp_valid,
    input  logic [1:0]             rsp_ready,
    output logic [DATA_W-1:0]      rsp_result,
    output logic [3:0]             rsp_status,
    output logic [DATA_W-1:0]      alu_in1,
    output logic [DATA_W-1:0]      alu_in2,
    output logic [DATA_W-1:0]      alu_c,
    output logic [CMD_W-1:0]       alu_cmd,
    input  logic [DATA_W-1:0]      alu_result,
    input  logic [3:0]             alu_status,
    output logic [3:0]             flags
);

    state_t            state;
    logic              grant;
    logic              accept;
    logic              owner;
    logic [CMD_W-1:0]  op_cmd;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              op_s;

    rr_arbiter2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .valid  (req_valid),
        .accept (accept),
        .grant  (grant)
    );

    // rst_n gate keeps ready low while reset is held with requests pending.
    always_comb begin
        req_ready = 2'b00;
        if ((state == IDLE) && rst_n) begin
            req_ready[grant] = req_valid[grant];
        end
    end

    assign accept = |req_ready;

    assign alu_in1 = op_a;
    assign alu_in2 = op_b;
    assign alu_cmd = op_cmd;
    assign alu_c   = {{(DATA_W-1){1'b0}}, flags[FL_C]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= 1'b0;
            op_cmd     <= '0;
            op_a       <= '0;
            op_b       <= '0;
            op_s       <= 1'b0;
            rsp_valid  <= 2'b00;
            rsp_result <= '0;
            rsp_status <= 4'b0000;
            flags      <= 4'b0000;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_cmd <= req_cmd[grant];
                        op_a   <= req_a[grant];
                        op_b   <= req_b[grant];
                        op_s   <= req_s[grant];
                        owner  <= grant;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result <= alu_result;
                    rsp_status <= alu_status;
                    rsp_valid  <= {owner, ~owner};
                    if (op_s) begin
                        flags <= status_to_flags(alu_status);
                    end
                    state <= RESP;
                end
                RESP: begin
                    // Only the owner's rsp_ready can retire the response.
                    if (rsp_ready[owner]) begin
                        rsp_valid <= 2'b00;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 2'b00;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb/tb_alu_share_ctrl.sv - directed self-checking bench for alu_share_ctrl with a behavioural ALU
module tb_alu_share_ctrl;
    import alu_share_ctrl_pkg::*;

    logic             clk;
    logic             rst_n;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0][3:0]  req_cmd;
    logic [1:0][31:0] req_a;
    logic [1:0][31:0] req_b;
    logic [1:0]       req_s;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [31:0]      rsp_result;
    logic [3:0]       rsp_status;
    logic [31:0]      alu_in1;
    logic [31:0]      alu_in2;
    logic [31:0]      alu_c;
    logic [3:0]       alu_cmd;
    logic [31:0]      alu_result;
    logic [3:0]       alu_status;
    logic [3:0]       flags;

    int checks;
    int errors;

    alu_share_ctrl #(.DATA_W(32), .CMD_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_cmd    (req_cmd),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_s      (req_s),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_status (rsp_status),
        .alu_in1    (alu_in1),
        .alu_in2    (alu_in2),
        .alu_c      (alu_c),
        .alu_cmd    (alu_cmd),
        .alu_result (alu_result),
        .alu_status (alu_status),
        .flags      (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ARM-style ALU: C is carry-out (not-borrow for subtraction), status {N,Z,V,C}
    always_comb begin
        logic [32:0] sum;
        logic [31:0] opb;
        logic        cin;
        logic        arith;
        logic        v;
        logic [31:0] r;
        sum   = '0;
        opb   = alu_in2;
        cin   = 1'b0;
        arith = 1'b0;
        v     = 1'b0;
        r     = '0;
        case (alu_cmd)
            CMD_ADD: begin arith = 1'b1; end
            CMD_ADC: begin arith = 1'b1; cin = alu_c[0]; end
            CMD_SUB: begin arith = 1'b1; opb = ~alu_in2; cin = 1'b1; end
            CMD_SBC: begin arith = 1'b1; opb = ~alu_in2; cin = alu_c[0]; end
            CMD_MOV: r = alu_in2;
            CMD_MVN: r = ~alu_in2;
            CMD_AND: r = alu_in1 & alu_in2;
            CMD_ORR: r = alu_in1 | alu_in2;
            CMD_EOR: r = alu_in1 ^ alu_in2;
            default: r = '0;
        endcase
        if (arith) begin
            sum = {1'b0, alu_in1} + {1'b0, opb} + {32'b0, cin};
            r   = sum[31:0];
            v   = (alu_in1[31] == opb[31]) && (r[31] != alu_in1[31]);
        end
        alu_result = r;
        alu_status = {r[31], (r == 32'd0), v, sum[32]};
    end

    task automatic pulse_reset;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic do_op(input int r, input logic [3:0] cmd, input logic [31:0] a,
                         input logic [31:0] b, input logic s, input logic [31:0] exp_c,
                         input logic [31:0] exp_res, input logic [3:0] exp_st,
                         input logic [3:0] exp_fl, input string name);
        logic [1:0] oh;
        oh = (r == 0) ? 2'b01 : 2'b10;
        @(negedge clk);
        req_cmd[r] = cmd; req_a[r] = a; req_b[r] = b; req_s[r] = s;
        req_valid  = oh;
        #1;
        checks++;
        if (req_ready !== oh) begin
            errors++; $display("FAIL %s req_ready: got %b expected %b", name, req_ready, oh);
        end
        @(negedge clk);
        req_valid = 2'b00;
        checks++;
        if (alu_in1 !== a || alu_in2 !== b || alu_cmd !== cmd || alu_c !== exp_c) begin
            errors++; $display("FAIL %s alu_drive: got %h %h %h %h expected %h %h %h %h",
                               name, alu_in1, alu_in2, alu_cmd, alu_c, a, b, cmd, exp_c);
        end
        checks++;
        if (rsp_valid !== 2'b00) begin
            errors++; $display("FAIL %s rsp_valid_exec: got %b expected 00", name, rsp_valid);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== oh) begin
            errors++; $display("FAIL %s rsp_valid: got %b expected %b", name, rsp_valid, oh);
        end
        checks++;
        if (rsp_result !== exp_res || rsp_status !== exp_st) begin
            errors++; $display("FAIL %s result: got %h/%b expected %h/%b",
                               name, rsp_result, rsp_status, exp_res, exp_st);
        end
        checks++;
        if (flags !== exp_fl) begin
            errors++; $display("FAIL %s flags: got %b expected %b", name, flags, exp_fl);
        end
        rsp_ready = oh;
        @(negedge clk);
        rsp_ready = 2'b00;
        checks++;
        if (rsp_valid !== 2'b00) begin
            errors++; $display("FAIL %s rsp_valid_after: got %b expected 00", name, rsp_valid);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req_valid = 2'b11; rsp_ready = 2'b00;
        req_cmd = '0; req_a = '0; req_b = '0; req_s = 2'b00;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b00 || rsp_valid !== 2'b00) begin
            errors++; $display("FAIL reset_handshake: got %b %b expected 00 00", req_ready, rsp_valid);
        end
        checks++;
        if (rsp_result !== 32'd0 || rsp_status !== 4'd0 || flags !== 4'd0) begin
            errors++; $display("FAIL reset_regs: got %h %b %b expected 0", rsp_result, rsp_status, flags);
        end
        checks++;
        if (alu_in1 !== 32'd0 || alu_in2 !== 32'd0 || alu_c !== 32'd0 || alu_cmd !== 4'd0) begin
            errors++; $display("FAIL reset_alu: got %h %h %h %h expected 0", alu_in1, alu_in2, alu_c, alu_cmd);
        end
        req_valid = 2'b00;
        rst_n = 1'b1;
    endtask

    task automatic test_add_basic;
        do_op(0, CMD_ADD, 32'd5, 32'd7, 1'b0, 32'd0, 32'd12, 4'b0000, 4'b0000, "add_5_7");
    endtask

    task automatic test_sub_flags;
        do_op(1, CMD_SUB, 32'd3, 32'd3, 1'b1, 32'd0, 32'd0, 4'b0101, 4'b0110, "sub_3_3");
    endtask

    task automatic test_carry_chain;
        do_op(0, CMD_ADD, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'd1, 32'd0, 4'b0101, 4'b0110, "add_wrap");
        do_op(1, CMD_ADC, 32'd1, 32'd1, 1'b0, 32'd1, 32'd3, 4'b0000, 4'b0110, "adc_1_1");
    endtask

    task automatic test_rsp_stall;
        @(negedge clk);
        req_cmd[0] = CMD_ADD; req_a[0] = 32'd2; req_b[0] = 32'd3; req_s[0] = 1'b0;
        req_valid = 2'b01;
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        req_cmd[1] = CMD_SUB; req_a[1] = 32'd9; req_b[1] = 32'd1; req_s[1] = 1'b1;
        req_valid = 2'b10;
        rsp_ready = 2'b10;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (rsp_valid !== 2'b01 || rsp_result !== 32'd5 || rsp_status !== 4'b0000) begin
                errors++; $display("FAIL stall_hold[%0d]: got %b %h %b expected 01 00000005 0000",
                                   i, rsp_valid, rsp_result, rsp_status);
            end
            checks++;
            if (req_ready !== 2'b00) begin
                errors++; $display("FAIL stall_ready[%0d]: got %b expected 00", i, req_ready);
            end
            @(negedge clk);
        end
        req_valid = 2'b00;
        rsp_ready = 2'b01;
        @(negedge clk);
        rsp_ready = 2'b00;
        checks++;
        if (rsp_valid !== 2'b00 || flags !== 4'b0110) begin
            errors++; $display("FAIL stall_release: got %b %b expected 00 0110", rsp_valid, flags);
        end
    endtask

    task automatic test_reset_exec;
        @(negedge clk);
        req_cmd[1] = CMD_ADD; req_a[1] = 32'd4; req_b[1] = 32'd4; req_s[1] = 1'b1;
        req_valid = 2'b10;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 2'b00 || req_ready !== 2'b00 || flags !== 4'b0000) begin
            errors++; $display("FAIL reset_exec: got %b %b %b expected 00 00 0000", rsp_valid, req_ready, flags);
        end
        checks++;
        if (alu_in1 !== 32'd0 || alu_in2 !== 32'd0 || alu_cmd !== 4'd0 || alu_c !== 32'd0) begin
            errors++; $display("FAIL reset_exec_alu: got %h %h %h %h expected 0", alu_in1, alu_in2, alu_cmd, alu_c);
        end
        req_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 2'b00) begin
                errors++; $display("FAIL reset_exec_norsp[%0d]: got %b expected 00", i, rsp_valid);
            end
        end
    endtask

    task automatic test_reset_resp;
        @(negedge clk);
        req_cmd[0] = CMD_ADD; req_a[0] = 32'h8000_0000; req_b[0] = 32'd0; req_s[0] = 1'b1;
        req_valid = 2'b01;
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 2'b01 || flags !== 4'b1000 || rsp_result !== 32'h8000_0000) begin
            errors++; $display("FAIL pre_reset_resp: got %b %b %h expected 01 1000 80000000",
                               rsp_valid, flags, rsp_result);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 2'b00 || rsp_result !== 32'd0 || rsp_status !== 4'd0 || flags !== 4'd0) begin
            errors++; $display("FAIL reset_resp: got %b %h %b %b expected 00 0 0000 0000",
                               rsp_valid, rsp_result, rsp_status, flags);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_round_robin;
        logic [1:0]  exp_oh;
        logic [31:0] exp_res;
        int          wait_cnt;
        pulse_reset();
        req_cmd[0] = CMD_ADD; req_a[0] = 32'd1;  req_b[0] = 32'd2;  req_s[0] = 1'b0;
        req_cmd[1] = CMD_ADD; req_a[1] = 32'd10; req_b[1] = 32'd20; req_s[1] = 1'b0;
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            exp_oh  = (k % 2 == 0) ? 2'b01 : 2'b10;
            exp_res = (k % 2 == 0) ? 32'd3 : 32'd30;
            wait_cnt = 0;
            @(negedge clk);
            while (rsp_valid === 2'b00 && wait_cnt < 8) begin
                @(negedge clk);
                wait_cnt++;
            end
            checks++;
            if (rsp_valid !== exp_oh) begin
                errors++; $display("FAIL rr_grant[%0d]: got %b expected %b", k, rsp_valid, exp_oh);
            end
            checks++;
            if (rsp_result !== exp_res) begin
                errors++; $display("FAIL rr_result[%0d]: got %h expected %h", k, rsp_result, exp_res);
            end
            rsp_ready = exp_oh;
            @(negedge clk);
            rsp_ready = 2'b00;
        end
        req_valid = 2'b00;
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_add_basic();
        test_sub_flags();
        test_carry_chain();
        test_rsp_stall();
        test_reset_exec();
        test_reset_resp();
        test_round_robin();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Sequencer and arbiter that shares the single combinational ALU between two requesters, such as the execute stage and an auxiliary address/compare unit. It accepts one operation at a time through a valid/ready handshake and grants round-robin when both requesters compete. It drives the ALU operand and command inputs, captures the result and status bits, and owns the architectural flag register {N,Z,C,V}. Each result is returned to the winning requester on a per-requester response channel.

## Interface
- DATA_W, 32, operand/result width (must match ALU)
- CMD_W, 4, ALU command width
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous and active-low
- req_valid[i], i=0..1  in  1  requester i has an operation
- req_ready[i]  out  1  controller accepts from requester i this cycle
- req_cmd[i]  in  CMD_W  ALU command
- req_a[i], req_b[i]  in  DATA_W  operands (in1, in2)
- req_s[i]  in  1  update flag register with this operation's status
- rsp_valid[i]  out  1  result pending for requester i
- rsp_ready[i]  in  1  requester i consumes result
- rsp_result  out  DATA_W  captured result, shared by both channels
- rsp_status  out  4  captured {N,Z,V,C}, shared by both channels
- alu_in1, alu_in2, alu_c  out  DATA_W  to ALU; alu_c = {DATA_W-1 zeros, flag C}
- alu_cmd  out  CMD_W  to ALU
- alu_result  in  DATA_W  from ALU
- alu_status  in  4  from ALU, order {N,Z,V,C}
- flags  out  4  architectural flag register {N,Z,C,V}

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE: req_ready[i] = req_valid[i] && (grant == i), and is 0 in every other state.
  - Grant goes to the only valid requester if just one is valid.
  - If both are valid, grant goes to the requester that is not last_grant.
  - On accept: latch cmd, a, b, s into the op register, set owner = i, set last_grant = i, go to EXEC.
- EXEC: drive alu_* from the op register. Capture alu_result and alu_status into the response register, then go to RESP.
  - If s=1, also load flags: N, Z and V from alu_status; C from alu_status bit 0.
- RESP: rsp_valid[owner] = 1 and the other rsp_valid = 0. Stay until rsp_ready[owner] = 1, then go to IDLE.
  - rsp_ready from the non-owner is ignored.
- alu_* outputs hold the op register contents in every state (no glitching to zero). The op register resets to 0.
- Flags are updated only in EXEC with s=1. Carry-in always comes from the current flags value.

## Timing
- Reset values: req_ready = 0, rsp_valid = 0, rsp_result = 0, rsp_status = 0, flags = 0, alu_* = 0, last_grant = 1 (so requester 0 wins first), owner = 0.
- Latency: accept at edge T, result captured at T+1, rsp_valid high from T+1. Minimum 3 cycles per operation; one operation outstanding.
- No accept in the same cycle as a response handshake. IDLE is always visited for one cycle.
- Requesters must hold req_* stable while valid and not ready. Requester behaviour after accept is don't-care.
- rsp_result and rsp_status are stable for the whole time rsp_valid is high.
- Simultaneous valid on both requesters after reset: requester 0 first, then 1, alternating while both stay valid.
- rst_n low in any state immediately returns to IDLE, drops the in-flight operation and clears flags. No response is issued for the dropped operation.

## Structure
- Shared package holds:
  - ALU command constants: MOV 0001, MVN 1001, ADD 0010, ADC 0011, SUB 0100, SBC 0101, AND 0110, ORR 0111, EOR 1000
  - FSM state enum
  - status bit index constants (N=3, Z=2, V=1, C=0)
- One natural sub-module: rr_arbiter2, a two-input round-robin grant with last_grant state.

## Test plan
- Requester 0 sends ADD 5 + 7 with s=0 -> rsp_valid[0] one cycle after accept, result 12, status 0000, flags stay 0000.
- Requester 1 sends SUB 3 - 3 with s=1 -> result 0, Z=1, flags Z set. rsp_valid[0] stays 0 throughout.
- ADD 0xFFFFFFFF + 1 with s=1 -> result 0, flags Z=1 and C=1. Then ADC 1 + 1 -> alu_c = 1 and result 3.
- Both requesters valid continuously from reset -> grants go 0, 1, 0, 1, and each response goes only to its owner.
- Hold rsp_ready low for 5 cycles in RESP -> rsp_valid and result stay stable, req_ready stays 0, and no new accept occurs.
- Assert rst_n low during EXEC or RESP -> all outputs return to reset values in the same cycle, with no response and flags 0000.
